// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and small helpers for the PS/2 set-2 decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Protocol prefix bytes
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    // Special keys handled outside the keymap
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SLASH  = 8'h4A;

    // Pause is E1 followed by seven more bytes that carry no key meaning
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_t;

    // Keyboard-to-host responses (BAT ok, ack, echo, resend, errors) are not keys
    function automatic logic is_response(input logic [7:0] c);
        return (c == 8'hAA) || (c == 8'hFA) || (c == 8'hEE) ||
               (c == 8'hFE) || (c == 8'h00) || (c == 8'hFF);
    endfunction

    // True for 'A'..'Z' and 'a'..'z'
    function automatic logic is_letter(input logic [7:0] c);
        logic [7:0] lc;
        lc = c | 8'h20;
        return (lc >= 8'h61) && (lc <= 8'h7A);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// US-layout set-2 scancode to ASCII map; bit 7 of the address selects the shifted plane.
// Latency: combinational.
// Backpressure: none; returns 0 for keys without a printable/control mapping.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] i_addr,
    output logic [7:0] o_ascii
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;

    // Both planes looked up from the low seven code bits
    always_comb begin
        w_lo = 8'h00;
        w_hi = 8'h00;
        case (i_addr[6:0])
            7'h0D: begin w_lo = 8'h09; w_hi = 8'h09; end  // tab
            7'h0E: begin w_lo = 8'h60; w_hi = 8'h7E; end  // ` ~
            7'h15: begin w_lo = "q";   w_hi = "Q";   end
            7'h16: begin w_lo = "1";   w_hi = "!";   end
            7'h1A: begin w_lo = "z";   w_hi = "Z";   end
            7'h1B: begin w_lo = "s";   w_hi = "S";   end
            7'h1C: begin w_lo = "a";   w_hi = "A";   end
            7'h1D: begin w_lo = "w";   w_hi = "W";   end
            7'h1E: begin w_lo = "2";   w_hi = "@";   end
            7'h21: begin w_lo = "c";   w_hi = "C";   end
            7'h22: begin w_lo = "x";   w_hi = "X";   end
            7'h23: begin w_lo = "d";   w_hi = "D";   end
            7'h24: begin w_lo = "e";   w_hi = "E";   end
            7'h25: begin w_lo = "4";   w_hi = "$";   end
            7'h26: begin w_lo = "3";   w_hi = "#";   end
            7'h29: begin w_lo = 8'h20; w_hi = 8'h20; end  // space
            7'h2A: begin w_lo = "v";   w_hi = "V";   end
            7'h2B: begin w_lo = "f";   w_hi = "F";   end
            7'h2C: begin w_lo = "t";   w_hi = "T";   end
            7'h2D: begin w_lo = "r";   w_hi = "R";   end
            7'h2E: begin w_lo = "5";   w_hi = "%";   end
            7'h31: begin w_lo = "n";   w_hi = "N";   end
            7'h32: begin w_lo = "b";   w_hi = "B";   end
            7'h33: begin w_lo = "h";   w_hi = "H";   end
            7'h34: begin w_lo = "g";   w_hi = "G";   end
            7'h35: begin w_lo = "y";   w_hi = "Y";   end
            7'h36: begin w_lo = "6";   w_hi = "^";   end
            7'h3A: begin w_lo = "m";   w_hi = "M";   end
            7'h3B: begin w_lo = "j";   w_hi = "J";   end
            7'h3C: begin w_lo = "u";   w_hi = "U";   end
            7'h3D: begin w_lo = "7";   w_hi = "&";   end
            7'h3E: begin w_lo = "8";   w_hi = "*";   end
            7'h41: begin w_lo = ",";   w_hi = "<";   end
            7'h42: begin w_lo = "k";   w_hi = "K";   end
            7'h43: begin w_lo = "i";   w_hi = "I";   end
            7'h44: begin w_lo = "o";   w_hi = "O";   end
            7'h45: begin w_lo = "0";   w_hi = ")";   end
            7'h46: begin w_lo = "9";   w_hi = "(";   end
            7'h49: begin w_lo = ".";   w_hi = ">";   end
            7'h4A: begin w_lo = "/";   w_hi = "?";   end
            7'h4B: begin w_lo = "l";   w_hi = "L";   end
            7'h4C: begin w_lo = ";";   w_hi = ":";   end
            7'h4D: begin w_lo = "p";   w_hi = "P";   end
            7'h4E: begin w_lo = "-";   w_hi = "_";   end
            7'h52: begin w_lo = 8'h27; w_hi = 8'h22; end  // ' "
            7'h54: begin w_lo = "[";   w_hi = "{";   end
            7'h55: begin w_lo = "=";   w_hi = "+";   end
            7'h5A: begin w_lo = 8'h0D; w_hi = 8'h0D; end  // enter
            7'h5B: begin w_lo = "]";   w_hi = "}";   end
            7'h5D: begin w_lo = 8'h5C; w_hi = 8'h7C; end  // \ |
            7'h66: begin w_lo = 8'h08; w_hi = 8'h08; end  // backspace
            7'h69: begin w_lo = "1";   w_hi = "1";   end  // keypad
            7'h6B: begin w_lo = "4";   w_hi = "4";   end
            7'h6C: begin w_lo = "7";   w_hi = "7";   end
            7'h70: begin w_lo = "0";   w_hi = "0";   end
            7'h71: begin w_lo = ".";   w_hi = ".";   end
            7'h72: begin w_lo = "2";   w_hi = "2";   end
            7'h73: begin w_lo = "5";   w_hi = "5";   end
            7'h74: begin w_lo = "6";   w_hi = "6";   end
            7'h75: begin w_lo = "8";   w_hi = "8";   end
            7'h76: begin w_lo = 8'h1B; w_hi = 8'h1B; end  // escape
            7'h79: begin w_lo = "+";   w_hi = "+";   end
            7'h7A: begin w_lo = "3";   w_hi = "3";   end
            7'h7B: begin w_lo = "-";   w_hi = "-";   end
            7'h7C: begin w_lo = "*";   w_hi = "*";   end
            7'h7D: begin w_lo = "9";   w_hi = "9";   end
            default: begin w_lo = 8'h00; w_hi = 8'h00; end
        endcase
    end

    assign o_ascii = i_addr[7] ? w_hi : w_lo;

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered head word and a drop indication.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: a push while full is taken only alongside a pop; otherwise o_drop pulses.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_drop,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    input  logic             i_pop_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic [AW-1:0]    w_rd_nxt;

    assign w_pop    = i_pop_rdy && (r_count != '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_push   = i_push_vld && (!w_full || w_pop);
    assign o_drop   = i_push_vld && w_full && !w_pop;
    assign w_rd_nxt = r_rd_ptr + AW'(1);

    // Storage array; no reset needed since only occupied slots are ever read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers, occupancy and the registered head word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Head follows the next stored word, or the bypassed push when
            // the FIFO is about to hold exactly that one word
            if (w_pop) begin
                if (r_count > CW'(1)) begin
                    r_head <= r_mem[w_rd_nxt];
                end else if (w_push) begin
                    r_head <= i_push_dat;
                end
            end else if (w_push && (r_count == '0)) begin
                r_head <= i_push_dat;
            end
        end
    end

    assign o_pop_vld = (r_count != '0);
    assign o_pop_dat = r_head;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: prefix FSM, modifier tracking, ASCII translation, buffered output.
// Latency: code_valid at N -> FIFO write at N+1 -> out_valid at N+2 when empty.
// Backpressure: valid/ready pop; characters arriving at a full FIFO are dropped, overflow sticks.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FORCE_UPPER = 0,
    parameter int MARK_BIT7   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       caps_led
);

    ps2_state_t r_state;
    ps2_state_t w_state_nxt;
    logic [2:0] r_skip_cnt;
    logic [2:0] w_skip_nxt;

    logic       r_shift_l, r_shift_r, r_ctrl, r_caps, r_caps_held;
    logic       w_shift_l_nxt, w_shift_r_nxt, w_ctrl_nxt, w_caps_nxt, w_caps_held_nxt;

    logic       w_xlate;
    logic       w_ext_vld;
    logic [7:0] w_ext_dat;

    logic       w_shift;
    logic [7:0] w_map;
    logic       w_letter;
    logic       w_upper;
    logic [7:0] w_cased;
    logic [7:0] w_ctl_base;
    logic [7:0] w_xlate_dat;
    logic       w_xlate_vld;
    logic       w_push_vld;
    logic [7:0] w_push_dat;

    logic       r_push_vld;
    logic [7:0] r_push_dat;
    logic       w_drop;
    logic       r_ovf;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
        end
    end

    // FSM next-state: prefixes steer the state, every state advances only on a byte
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code == SC_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (code == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (code == SC_PAUSE) begin
                        w_state_nxt = ST_SKIP;
                        w_skip_nxt  = PAUSE_SKIP;
                    end
                end
                ST_BRK:     w_state_nxt = ST_IDLE;
                ST_EXT:     w_state_nxt = (code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: w_state_nxt = ST_IDLE;
                ST_SKIP: begin
                    w_skip_nxt = r_skip_cnt - 3'd1;
                    if (r_skip_cnt == 3'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: modifier updates, translate request and extended-key characters
    always_comb begin
        w_shift_l_nxt   = r_shift_l;
        w_shift_r_nxt   = r_shift_r;
        w_ctrl_nxt      = r_ctrl;
        w_caps_nxt      = r_caps;
        w_caps_held_nxt = r_caps_held;
        w_xlate         = 1'b0;
        w_ext_vld       = 1'b0;
        w_ext_dat       = 8'h00;
        if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code != SC_BRK && code != SC_EXT && code != SC_PAUSE &&
                        !is_response(code)) begin
                        case (code)
                            SC_LSHIFT: w_shift_l_nxt = 1'b1;
                            SC_RSHIFT: w_shift_r_nxt = 1'b1;
                            SC_CTRL:   w_ctrl_nxt    = 1'b1;
                            SC_CAPS: begin
                                // Typematic repeats arrive while held and must not re-toggle
                                if (!r_caps_held) begin
                                    w_caps_nxt = !r_caps;
                                end
                                w_caps_held_nxt = 1'b1;
                            end
                            SC_ALT:    w_xlate = 1'b0;
                            default:   w_xlate = 1'b1;
                        endcase
                    end
                end
                ST_BRK: begin
                    case (code)
                        SC_LSHIFT: w_shift_l_nxt   = 1'b0;
                        SC_RSHIFT: w_shift_r_nxt   = 1'b0;
                        SC_CTRL:   w_ctrl_nxt      = 1'b0;
                        SC_CAPS:   w_caps_held_nxt = 1'b0;
                        default:   w_xlate         = 1'b0;
                    endcase
                end
                ST_EXT: begin
                    case (code)
                        SC_CTRL:  w_ctrl_nxt = 1'b1;
                        SC_ENTER: begin w_ext_vld = 1'b1; w_ext_dat = ASCII_CR;    end
                        SC_SLASH: begin w_ext_vld = 1'b1; w_ext_dat = ASCII_SLASH; end
                        default:  w_ext_vld = 1'b0;
                    endcase
                end
                ST_EXT_BRK: begin
                    if (code == SC_CTRL) begin
                        w_ctrl_nxt = 1'b0;
                    end
                end
                default: w_xlate = 1'b0;
            endcase
        end
    end

    assign w_shift = r_shift_l | r_shift_r;

    ps2_keymap u_keymap (
        .i_addr  ({w_shift, code[6:0]}),
        .o_ascii (w_map)
    );

    // Letter case, ctrl folding and bit-7 marking of the translated character
    always_comb begin
        w_letter    = is_letter(w_map);
        w_upper     = (w_shift ^ r_caps) || (FORCE_UPPER != 0);
        w_cased     = w_map;
        if (w_letter) begin
            w_cased = w_upper ? (w_map & 8'hDF) : (w_map | 8'h20);
        end
        // Ctrl acts on the upper-case form so ctrl-c and ctrl-C both give ETX
        w_ctl_base  = w_letter ? (w_cased & 8'hDF) : w_cased;
        w_xlate_dat = w_cased;
        if (r_ctrl && (w_ctl_base >= 8'h40) && (w_ctl_base <= 8'h5F)) begin
            w_xlate_dat = w_ctl_base & 8'h1F;
        end
        w_xlate_vld = w_xlate && !code[7] && (w_map != 8'h00);
        w_push_vld  = w_xlate_vld || w_ext_vld;
        w_push_dat  = w_ext_vld ? w_ext_dat : w_xlate_dat;
        if (MARK_BIT7 != 0) begin
            w_push_dat[7] = 1'b1;
        end
    end

    // Key state and the staged push toward the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_ctrl      <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_push_vld  <= 1'b0;
            r_push_dat  <= 8'h00;
        end else begin
            r_shift_l   <= w_shift_l_nxt;
            r_shift_r   <= w_shift_r_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_caps      <= w_caps_nxt;
            r_caps_held <= w_caps_held_nxt;
            r_push_vld  <= w_push_vld;
            r_push_dat  <= w_push_dat;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_vld (r_push_vld),
        .i_push_dat (r_push_dat),
        .o_drop     (w_drop),
        .o_pop_vld  (out_valid),
        .o_pop_dat  (out_data),
        .i_pop_rdy  (out_ready)
    );

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign overflow = r_ovf;
    assign caps_led = r_caps;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] code;
    logic       code_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       ovf_clr;
    logic       caps_led;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_overflow;
    logic       m_ovf_clr;
    logic       m_caps_led;

    int n_cmp;
    int n_fail;

    ps2_key_decoder #(.FIFO_DEPTH(8), .FORCE_UPPER(0), .MARK_BIT7(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .code       (code),
        .code_valid (code_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .caps_led   (caps_led)
    );

    ps2_key_decoder #(.FIFO_DEPTH(8), .FORCE_UPPER(0), .MARK_BIT7(1)) dut_mark (
        .clk        (clk),
        .reset      (reset),
        .code       (code),
        .code_valid (code_valid),
        .out_data   (m_data),
        .out_valid  (m_valid),
        .out_ready  (m_ready),
        .overflow   (m_overflow),
        .ovf_clr    (m_ovf_clr),
        .caps_led   (m_caps_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        code       = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    // Waits a bounded time for a character and pops it; x on timeout
    task automatic pop_char(output logic [7:0] d);
        bit done;
        d    = 'x;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (out_valid === 1'b1) begin
                d         = out_data;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                done      = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        cycles(2);
        #3;
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (caps_led !== 1'b0) begin n_fail++; $display("FAIL reset_caps_led: got %b want 0", caps_led); end
        cycles(2);
        #3;
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_make_break();
        logic [7:0] d;
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL make_a: got %h want 61", d); end
        cycles(4);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL break_silent: got valid %b want 0", out_valid); end
    endtask

    task automatic test_shift();
        logic [7:0] d;
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1C);
        pop_char(d);
        n_cmp++; if (d !== 8'h41) begin n_fail++; $display("FAIL shift_A: got %h want 41", d); end
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL shift_released_a: got %h want 61", d); end
        cycles(4);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL shift_extra: got valid %b want 0", out_valid); end
    endtask

    task automatic test_caps();
        logic [7:0] d;
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h58);
        n_cmp++; if (caps_led !== 1'b1) begin n_fail++; $display("FAIL caps_on: got %b want 1", caps_led); end
        send_byte(8'h1C);
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        pop_char(d);
        n_cmp++; if (d !== 8'h41) begin n_fail++; $display("FAIL caps_A: got %h want 41", d); end
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL caps_shift_a: got %h want 61", d); end
        // typematic repeat: two makes then one break toggle only once
        send_byte(8'h58);
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h58);
        n_cmp++; if (caps_led !== 1'b0) begin n_fail++; $display("FAIL caps_repeat: got %b want 0", caps_led); end
    endtask

    task automatic test_ctrl_ext();
        logic [7:0] d;
        send_byte(8'h14);
        send_byte(8'h21);
        send_byte(8'hF0);
        send_byte(8'h14);
        pop_char(d);
        n_cmp++; if (d !== 8'h03) begin n_fail++; $display("FAIL ctrl_c: got %h want 03", d); end
        send_byte(8'hE0);
        send_byte(8'h14);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'h1C);
        pop_char(d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL rctrl_a: got %h want 01", d); end
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL rctrl_released_a: got %h want 61", d); end
        send_byte(8'hE0);
        send_byte(8'h5A);
        pop_char(d);
        n_cmp++; if (d !== 8'h0D) begin n_fail++; $display("FAIL kp_enter: got %h want 0d", d); end
        send_byte(8'hE0);
        send_byte(8'h4A);
        pop_char(d);
        n_cmp++; if (d !== 8'h2F) begin n_fail++; $display("FAIL kp_slash: got %h want 2f", d); end
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'h7C);
        cycles(4);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ext_silent: got valid %b want 0", out_valid); end
    endtask

    task automatic test_pause();
        logic [7:0] d;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        send_byte(8'h1C);
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL pause_then_a: got %h want 61", d); end
        cycles(4);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pause_silent: got valid %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        @(posedge clk);
        #1;
        code_valid = 1'b1;
        code = 8'h1C; cycles(1);
        code = 8'h32; cycles(1);
        code = 8'h21; cycles(1);
        code_valid = 1'b0;
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL b2b_a: got %h want 61", d); end
        pop_char(d);
        n_cmp++; if (d !== 8'h62) begin n_fail++; $display("FAIL b2b_b: got %h want 62", d); end
        pop_char(d);
        n_cmp++; if (d !== 8'h63) begin n_fail++; $display("FAIL b2b_c: got %h want 63", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        int good;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'h1C);
        cycles(3);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        good = 0;
        for (int i = 0; i < 8; i++) begin
            pop_char(d);
            if (d === 8'h61) good++;
        end
        n_cmp++; if (good != 8) begin n_fail++; $display("FAIL ovf_held: got %0d chars want 8", good); end
        cycles(1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got valid %b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    endtask

    task automatic test_mark();
        logic [7:0] d;
        do_reset();
        send_byte(8'h1C);
        cycles(3);
        n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mark_valid: got %b want 1", m_valid); end
        n_cmp++; if (m_data !== 8'hE1) begin n_fail++; $display("FAIL mark_data: got %h want e1", m_data); end
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL nomark_data: got %h want 61", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        send_byte(8'h1C);
        send_byte(8'hF0);
        cycles(2);
        #2;
        reset = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h want 00", out_data); end
        cycles(1);
        #3;
        reset = 1'b0;
        send_byte(8'h1C);
        pop_char(d);
        n_cmp++; if (d !== 8'h61) begin n_fail++; $display("FAIL midreset_next: got %h want 61", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        code       = 8'h00;
        code_valid = 1'b0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
        m_ready    = 1'b0;
        m_ovf_clr  = 1'b0;
        cycles(2);
        reset = 1'b0;
        test_reset();
        test_make_break();
        test_shift();
        test_caps();
        test_ctrl_ext();
        test_pause();
        test_back_to_back();
        test_overflow();
        test_mark();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Stateful PS/2 set-2 keyboard decoder. Consumes raw scancode bytes from the PS/2 receiver and tracks make/break, E0/E1 prefixes, shift, ctrl and caps-lock state. Translates key makes to ASCII and buffers the characters in a parametrised output FIFO with a valid/ready handshake toward the console/TTY interface. Successor to the flat shifted-address keymap ROM: adds modifier tracking, ctrl codes, caps lock, output modes and buffering.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; power of 2, range 2..64
FORCE_UPPER, 0, 1 = letters always upper case, ignoring shift and caps
MARK_BIT7, 0, 1 = force out_data[7]=1 (mark parity for PDP-8 terminal software)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
code  in  8  scancode byte from PS/2 receiver
code_valid  in  1  one-cycle strobe; code is valid
out_data  out  8  ASCII character at FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer pops the head when out_valid & out_ready
overflow  out  1  sticky; a character was dropped because the FIFO was full
ovf_clr  in  1  clears overflow
caps_led  out  1  current caps-lock state, for the keyboard LED path

Behaviour:
- Reset (async, active-high): FSM=IDLE; shift_l, shift_r, ctrl, caps, caps_held=0; FIFO empty; out_valid=0; out_data=0; overflow=0; caps_led=0.
- FSM states, advanced only on code_valid:
  - IDLE: F0->BRK; E0->EXT; E1->SKIP (cnt=7); AA/FA/EE/FE/00/FF ignored; otherwise MAKE action.
  - BRK: break action on code; ->IDLE.
  - EXT: F0->EXT_BRK; otherwise extended make; ->IDLE.
  - EXT_BRK: extended break; ->IDLE.
  - SKIP: discard byte; cnt-=1; ->IDLE when cnt reaches 0. Pause sequence E1 14 77 E1 F0 14 F0 77 is swallowed entirely.
- MAKE:
  - 12 / 59 set shift_l / shift_r.
  - 14 sets ctrl.
  - 58 toggles caps only if caps_held=0, then sets caps_held (typematic repeat does not re-toggle).
  - 11 is ignored.
  - Otherwise translate.
- BREAK:
  - 12 / 59 / 14 clear the matching modifier.
  - 58 clears caps_held.
  - Other codes produce no output.
- Extended:
  - Make 14 sets ctrl; break 14 clears ctrl.
  - Make 5A yields 0x0D; make 4A yields '/'.
  - All other extended codes, including the fake shift E0 12, produce nothing.
- Translate: keymap lookup with address {shift, code[6:0]}, where shift = shift_l|shift_r. code[7]=1 produces nothing.
  - Letters: case is upper iff (shift XOR caps), or FORCE_UPPER=1.
  - Ctrl: if the result after upper-casing is in 0x40..0x5F, the output is result & 0x1F; other results pass unchanged.
  - A map result of 0 produces no push.
  - If MARK_BIT7=1, bit 7 is set on push.
- Latency: code_valid at cycle N -> FIFO write at N+1 -> out_valid=1 at N+2 when the FIFO was empty. Throughput is one byte per cycle.
- FIFO: out_data is the registered head.
  - A push while full is accepted only if a pop occurs in the same cycle. Otherwise the character is dropped and overflow is set.
  - A simultaneous push and pop when empty is impossible, because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
- overflow: ovf_clr clears it. A set and a clear in the same cycle leaves overflow set.
- Modifiers persist across FIFO full; key state is never dropped.

Decomposition:
- Package ps2_pkg:
  - Prefix/special constants (F0, E0, E1, LSHIFT=12, RSHIFT=59, CTRL=14, CAPS=58, ENTER=5A, SLASH=4A).
  - FSM state enum {IDLE, BRK, EXT, EXT_BRK, SKIP}.
  - Ignored-response code list.
- Sub-module ps2_keymap: combinational 8-bit address -> 8-bit ASCII map (unshifted and shifted US layout), instantiated once.
- FIFO inline, or as generic sync_fifo if the library has one.

Test Plan:
- Bytes 1C, F0 1C -> one char 0x61; no output on the break.
- 12, 1C, F0 1C, F0 12, 1C -> 0x41 then 0x61; shift clear after its break.
- 58, F0 58, 1C, 12, 1C -> caps_led=1; chars 0x41, 0x61 (shift XORs caps). Repeat 58 58 F0 58 -> caps_led toggles once.
- 14, 21 -> 0x03. E0 14, 1C, E0 F0 14, 1C -> 0x01 then 0x61. E0 5A -> 0x0D. E0 12 E0 7C -> no output.
- E1 14 77 E1 F0 14 F0 77 then 1C -> only 0x61 emitted; FSM back in IDLE.
- out_ready=0, FIFO_DEPTH+2 makes of 1C -> FIFO_DEPTH chars held, overflow=1. ovf_clr -> 0. MARK_BIT7=1 run -> out_data=0xE1. Async reset mid-sequence (after F0) -> out_valid=0 and next 1C yields 0x61.
